sram_port_ctrl: RTL and testbench

Request-side controller for one RW port of the 32-bit × 128-word dual-port SRAM macro. It accepts read and write requests over a valid/ready interface and drives the macro's active-low port pins. It captures read data one edge after issue and returns it through a response buffer with backpressure. Each SRAM port gets one instance; the datapath (cache/scratchpad logic) sits upstream.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_port_ctrl_if.sv | 28 ++
 rtl/sram_rsp_fifo.sv | 59 +++++
 rtl/sram_port_ctrl.sv | 89 ++++++++
 tb/tb_sram_port_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port controller: macro geometry, request
// bundle and read-tracking states.
package sram_pkg;

    localparam int SRAM_DATA_WIDTH = 32;
    localparam int SRAM_ADDR_WIDTH = 7;

    typedef struct packed {
        logic                       we;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_PEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response handshake bundle between an upstream client (master) and
// the SRAM port controller (slave).
interface sram_port_ctrl_if
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; the head reads as zero when
// empty so the response bus is quiet out of reset.
module sram_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CNT_W-1:0]      count,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign rdata  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk0) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Request-side controller for one RW port of the dual-port SRAM macro: drives
// the active-low pins, captures read data one edge after issue, and buffers it.
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_port_ctrl_if.slave       bus,
    output logic                  csb,
    output logic                  web,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  idle
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CR_W  = CNT_W + 1;

    sram_req_t        req;
    rd_state_t        state;
    rd_state_t        state_nxt;
    logic             fire;
    logic             rd_fire;
    logic             rd_pend;
    logic             pop;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CR_W-1:0]  credit_used;

    assign req.we    = bus.req_we;
    assign req.addr  = bus.req_addr;
    assign req.wdata = bus.req_wdata;

    // Credits count both buffered entries and the read whose data arrives next
    // edge, so a capture can never find the FIFO full.
    assign rd_pend       = (state == RD_PEND);
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign credit_used   = CR_W'(count) + CR_W'(rd_pend) - CR_W'(pop);
    assign bus.req_ready = !rst0 && (credit_used < CR_W'(RSP_DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;
    assign rd_fire       = fire && !req.we;

    assign csb  = !fire;
    assign web  = !(fire && req.we);
    assign addr = req.addr;
    assign din  = req.wdata;

    assign bus.rsp_valid = !empty;
    assign idle          = !rd_pend && empty;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RD_IDLE;
        case (state)
            RD_IDLE: state_nxt = rd_fire ? RD_PEND : RD_IDLE;
            RD_PEND: state_nxt = rd_fire ? RD_PEND : RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Macro output is valid on the edge after issue; push it then.
    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rsp_fifo (
        .clk0  (clk0),
        .rst0  (rst0),
        .push  (rd_pend),
        .pop   (pop),
        .wdata (dout),
        .rdata (bus.rsp_rdata),
        .count (count),
        .empty (empty)
    );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural model of the SRAM macro
// port (pins sampled on posedge, dout updated after negedge).
module tb_sram_port_ctrl;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        csb;
    logic        web;
    logic [6:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        idle;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [128];
    logic [6:0]  rd_addr;

    sram_port_ctrl_if bus ();

    sram_port_ctrl dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus),
        .csb  (csb),
        .web  (web),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .idle (idle)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) begin
        if (!csb) begin
            if (!web) mem[addr] <= din;
            else      rd_addr   <= addr;
        end
    end

    always @(negedge clk0) dout <= mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [6:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        rd_addr       = '0;
        dout          = '0;
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 7'h0, 32'h0);

        // reset values with a request pending
        #12;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_csb",       {31'b0, csb}, 32'd1);
        chk("rst_web",       {31'b0, web}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_idle",      {31'b0, idle}, 32'd1);
        drive(1'b0, 1'b0, 7'h0, 32'h0);
        step();
        rst0 = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("post_rst_idle",  {31'b0, idle}, 32'd1);

        // write then read
        bus.rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 7'h05, 32'hDEADBEEF);
        #1;
        chk("wr_csb",  {31'b0, csb}, 32'd0);
        chk("wr_web",  {31'b0, web}, 32'd0);
        chk("wr_addr", {25'b0, addr}, 32'h05);
        chk("wr_din",  din, 32'hDEADBEEF);
        step();
        drive(1'b1, 1'b0, 7'h05, 32'h0);
        #1;
        chk("rd_web",       {31'b0, web}, 32'd1);
        chk("rd_csb",       {31'b0, csb}, 32'd0);
        chk("wr_no_rsp",    {31'b0, bus.rsp_valid}, 32'd0);
        step();
        drive(1'b0, 1'b0, 7'h0, 32'h0);
        chk("rd_lat1_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rd_lat1_idle",  {31'b0, idle}, 32'd0);
        step();
        chk("rd_lat2_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("rd_lat2_data",  bus.rsp_rdata, 32'hDEADBEEF);
        step();
        chk("rd_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rd_done_idle",  {31'b0, idle}, 32'd1);

        // preload 0..7 then back-to-back reads
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 7'(i), 32'h11111111 * i);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 7'(i), 32'h0);
            else       drive(1'b0, 1'b0, 7'h0, 32'h0);
            #1;
            if (i < 8) chk($sformatf("b2b_ready_%0d", i), {31'b0, bus.req_ready}, 32'd1);
            if (i >= 2) begin
                chk($sformatf("b2b_valid_%0d", i - 2), {31'b0, bus.rsp_valid}, 32'd1);
                chk($sformatf("b2b_data_%0d", i - 2), bus.rsp_rdata, 32'h11111111 * (i - 2));
            end
            step();
        end
        chk("b2b_idle", {31'b0, idle}, 32'd1);

        // backpressure
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 7'h01, 32'h0);
        #1;
        chk("bp_ready0", {31'b0, bus.req_ready}, 32'd1);
        step();
        drive(1'b1, 1'b0, 7'h02, 32'h0);
        #1;
        chk("bp_ready1", {31'b0, bus.req_ready}, 32'd1);
        step();
        drive(1'b1, 1'b0, 7'h03, 32'h0);
        #1;
        chk("bp_ready2", {31'b0, bus.req_ready}, 32'd0);
        chk("bp_head0",  bus.rsp_rdata, 32'h11111111);
        step();
        chk("bp_ready3", {31'b0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_pop_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("bp_pop_data",  bus.rsp_rdata, 32'h11111111);
        step();
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 7'h0, 32'h0);
        #1;
        chk("bp_head1", bus.rsp_rdata, 32'h22222222);
        step();
        chk("bp_full_ready", {31'b0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_drain1", bus.rsp_rdata, 32'h22222222);
        step();
        chk("bp_drain2", bus.rsp_rdata, 32'h33333333);
        step();
        chk("bp_empty", {31'b0, bus.rsp_valid}, 32'd0);

        // mixed traffic on the top address
        drive(1'b1, 1'b1, 7'h7F, 32'h1);
        step();
        drive(1'b1, 1'b0, 7'h7F, 32'h0);
        step();
        drive(1'b1, 1'b1, 7'h7F, 32'h2);
        #1;
        chk("mix_w_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        step();
        drive(1'b1, 1'b0, 7'h7F, 32'h0);
        #1;
        chk("mix_rsp1", bus.rsp_rdata, 32'h1);
        step();
        drive(1'b0, 1'b0, 7'h0, 32'h0);
        chk("mix_gap", {31'b0, bus.rsp_valid}, 32'd0);
        step();
        chk("mix_rsp2_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("mix_rsp2",       bus.rsp_rdata, 32'h2);
        step();

        // reset with a read in flight and one entry buffered
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 7'h05, 32'h0);
        step();
        drive(1'b1, 1'b0, 7'h06, 32'h0);
        step();
        chk("inflight_valid", {31'b0, bus.rsp_valid}, 32'd1);
        rst0 = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("midrst_rdata", bus.rsp_rdata, 32'h0);
        chk("midrst_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("midrst_csb",   {31'b0, csb}, 32'd1);
        chk("midrst_idle",  {31'b0, idle}, 32'd1);
        drive(1'b0, 1'b0, 7'h0, 32'h0);
        step();
        rst0 = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("postrst_valid_%0d", i), {31'b0, bus.rsp_valid}, 32'd0);
            chk($sformatf("postrst_idle_%0d", i), {31'b0, idle}, 32'd1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
